// File: rtl/mips_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mips_dmem_bridge
// Description : Data-memory port bridge behind the MEM stage of the 5-stage
//               MIPS core. Turns single-cycle load/store strobes into a
//               req/ack bus transaction with any number of wait states,
//               stalls the pipeline until the access retires and presents
//               registered load data. Flags misaligned accesses and bus
//               timeouts with sticky error bits.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_WIDTH      core/bus address width (>= 2)
//   DATA_WIDTH      data word width; word-only accesses
//   TIMEOUT         max cycles waiting for busAck__i before abort (>= 1)
// Ports
//   clock__i        in   single clock, rising edge
//   reset_n__i      in   asynchronous active-low reset
//   memAddr__i      in   core data address
//   memDataWrite__i in   core store data
//   memRead__i      in   core load strobe
//   memWrite__i     in   core store strobe (wins when both strobes are high)
//   memDataRead__o  out  registered load data to MEM/WB
//   stall__o        out  pipeline freeze
//   busReq__o       out  bus request, held until ack or timeout
//   busWe__o        out  1 = write, 0 = read
//   busAddr__o      out  bus word address
//   busWData__o     out  bus write data
//   busAck__i       in   one-cycle completion strobe
//   busRData__i     in   read data, valid with busAck__i
//   misalignErr__o  out  sticky misaligned-access flag
//   timeoutErr__o   out  sticky bus-timeout flag
// ============================================================================
module mips_dmem_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock__i,
  input  logic                  reset_n__i,
  input  logic [ADDR_WIDTH-1:0] memAddr__i,
  input  logic [DATA_WIDTH-1:0] memDataWrite__i,
  input  logic                  memRead__i,
  input  logic                  memWrite__i,
  output logic [DATA_WIDTH-1:0] memDataRead__o,
  output logic                  stall__o,
  output logic                  busReq__o,
  output logic                  busWe__o,
  output logic [ADDR_WIDTH-1:0] busAddr__o,
  output logic [DATA_WIDTH-1:0] busWData__o,
  input  logic                  busAck__i,
  input  logic [DATA_WIDTH-1:0] busRData__i,
  output logic                  misalignErr__o,
  output logic                  timeoutErr__o
);

  // Counter is wide enough to hold TIMEOUT itself.
  localparam int                 c_CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT_CNT = c_CNT_W'(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_bus_req;
  logic [c_CNT_W-1:0]    r_cnt;
  logic                  r_misalign_err;
  logic                  r_timeout_err;

  logic                  w_req;
  logic                  w_aligned;
  logic [c_CNT_W-1:0]    w_cnt_inc;
  logic                  w_timeout;
  logic                  w_stall;

  assign w_req     = memRead__i | memWrite__i;
  assign w_aligned = (memAddr__i[1:0] == 2'b00);
  assign w_cnt_inc = r_cnt + c_CNT_ONE;
  // Fires in the last REQ cycle the bridge is willing to wait; an ack in
  // that same cycle still completes the access normally.
  assign w_timeout = (w_cnt_inc == c_TIMEOUT_CNT);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock__i or negedge reset_n__i) begin
    if (!reset_n__i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and stall. Stall is combinational from the strobes in IDLE so
  // the core holds the access in the very cycle it is first presented.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_stall     = 1'b1;
          w_state_nxt = w_aligned ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (busAck__i || w_timeout) begin
          w_state_nxt = S_DONE;
        end
      end
      // Strobes still high here belong to the retiring access.
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: latched request, bus request flop, wait counter, load data and
  // sticky error flags.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock__i or negedge reset_n__i) begin
    if (!reset_n__i) begin
      r_addr         <= '0;
      r_wdata        <= '0;
      r_we           <= 1'b0;
      r_rdata        <= '0;
      r_bus_req      <= 1'b0;
      r_cnt          <= '0;
      r_misalign_err <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_aligned) begin
              r_addr    <= memAddr__i;
              r_wdata   <= memDataWrite__i;
              r_we      <= memWrite__i;
              r_bus_req <= 1'b1;
              r_cnt     <= '0;
            end else begin
              // No bus cycle for a misaligned word access.
              r_misalign_err <= 1'b1;
              r_rdata        <= '0;
            end
          end
        end
        S_REQ: begin
          r_cnt <= w_cnt_inc;
          if (busAck__i) begin
            r_bus_req <= 1'b0;
            // Stores leave the last load result visible to the core.
            if (!r_we) begin
              r_rdata <= busRData__i;
            end
          end else if (w_timeout) begin
            r_bus_req     <= 1'b0;
            r_timeout_err <= 1'b1;
            r_rdata       <= '0;
          end
        end
        S_DONE: begin
          r_cnt <= '0;
        end
        default: begin
          r_bus_req <= 1'b0;
          r_cnt     <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign stall__o       = w_stall;
  assign busReq__o      = r_bus_req;
  assign busWe__o       = r_we;
  assign busAddr__o     = r_addr;
  assign busWData__o    = r_wdata;
  assign memDataRead__o = r_rdata;
  assign misalignErr__o = r_misalign_err;
  assign timeoutErr__o  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_mips_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_dmem_bridge
// Description : Self-checking bench for mips_dmem_bridge. The bench plays the
//               role of both the core (strobes) and the memory (ack with a
//               chosen number of wait states). Expected stall length, bus
//               cycle length, load data and error flags come from a small
//               access-level model. A second instance with TIMEOUT=4 covers
//               the short-timeout scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_dmem_bridge;

  localparam int c_TO_MAIN = 8;
  localparam int c_TO_T4   = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  logic [31:0] mem_rdata,  mem_rdata_t4;
  logic        stall,      stall_t4;
  logic        bus_req,    bus_req_t4;
  logic        bus_we,     bus_we_t4;
  logic [31:0] bus_addr,   bus_addr_t4;
  logic [31:0] bus_wdata,  bus_wdata_t4;
  logic        mis_err,    mis_err_t4;
  logic        to_err,     to_err_t4;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Access-level model state
  logic [31:0] exp_rdata;
  logic        exp_mis;
  logic        exp_to;

  mips_dmem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(c_TO_MAIN)) u_dut (
    .clock__i(clk), .reset_n__i(rst_n),
    .memAddr__i(mem_addr), .memDataWrite__i(mem_wdata),
    .memRead__i(mem_read), .memWrite__i(mem_write),
    .memDataRead__o(mem_rdata), .stall__o(stall),
    .busReq__o(bus_req), .busWe__o(bus_we),
    .busAddr__o(bus_addr), .busWData__o(bus_wdata),
    .busAck__i(bus_ack), .busRData__i(bus_rdata),
    .misalignErr__o(mis_err), .timeoutErr__o(to_err)
  );

  mips_dmem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(c_TO_T4)) u_dut_t4 (
    .clock__i(clk), .reset_n__i(rst_n),
    .memAddr__i(mem_addr), .memDataWrite__i(mem_wdata),
    .memRead__i(mem_read), .memWrite__i(mem_write),
    .memDataRead__o(mem_rdata_t4), .stall__o(stall_t4),
    .busReq__o(bus_req_t4), .busWe__o(bus_we_t4),
    .busAddr__o(bus_addr_t4), .busWData__o(bus_wdata_t4),
    .busAck__i(bus_ack), .busRData__i(bus_rdata),
    .misalignErr__o(mis_err_t4), .timeoutErr__o(to_err_t4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds reset for two cycles; starts and ends on a falling edge.
  task automatic pulse_reset();
    rst_n   = 1'b0;
    bus_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    exp_rdata = '0;
    exp_mis   = 1'b0;
    exp_to    = 1'b0;
  endtask

  // One core access against u_dut. Entered on a falling edge with the bridge
  // idle; returns on the falling edge of the first cycle after retirement.
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wd,
                           input logic rd, input logic wr, input int w,
                           input logic [31:0] ackd, input string nm);
    int          n_stall = 0;
    int          n_req   = 0;
    int          cyc     = 0;
    bit          bad     = 0;
    int          exp_stall;
    int          exp_req;
    logic [31:0] exp_rd;

    if (addr[1:0] != 2'b00) begin
      exp_stall = 1; exp_req = 0; exp_rd = '0; exp_mis = 1'b1;
    end else if (w < c_TO_MAIN) begin
      exp_stall = 2 + w; exp_req = w + 1;
      exp_rd    = wr ? exp_rdata : ackd;
    end else begin
      exp_stall = 1 + c_TO_MAIN; exp_req = c_TO_MAIN; exp_rd = '0; exp_to = 1'b1;
    end

    mem_addr  = addr;
    mem_wdata = wd;
    mem_read  = rd;
    mem_write = wr;
    #1;
    // The strobe cycle itself must not show a bus request.
    if (bus_req !== 1'b0) bad = 1;
    while (stall === 1'b1 && cyc < 64) begin
      n_stall++;
      if (bus_req === 1'b1) begin
        if (bus_we !== wr || bus_addr !== addr || bus_wdata !== wd) bad = 1;
        if (n_req == w) begin
          bus_ack   = 1'b1;
          bus_rdata = ackd;
        end
        n_req++;
      end
      @(posedge clk); #1;
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      @(negedge clk); #1;
      cyc++;
    end
    if (bus_req !== 1'b0) bad = 1;

    vec_cnt++;
    if (cyc >= 64) begin
      err_cnt++;
      $display("FAIL %s completion: stall still %b after %0d cycles, required low", nm, stall, cyc);
    end
    vec_cnt++;
    if (n_stall !== exp_stall) begin
      err_cnt++;
      $display("FAIL %s stall_cycles: got %0d required %0d", nm, n_stall, exp_stall);
    end
    vec_cnt++;
    if (n_req !== exp_req) begin
      err_cnt++;
      $display("FAIL %s busreq_cycles: got %0d required %0d", nm, n_req, exp_req);
    end
    vec_cnt++;
    if (mem_rdata !== exp_rd) begin
      err_cnt++;
      $display("FAIL %s rdata: got %h required %h", nm, mem_rdata, exp_rd);
    end
    vec_cnt++;
    if (mis_err !== exp_mis || to_err !== exp_to) begin
      err_cnt++;
      $display("FAIL %s flags: got mis=%b to=%b required mis=%b to=%b", nm, mis_err, to_err, exp_mis, exp_to);
    end
    vec_cnt++;
    if (bad) begin
      err_cnt++;
      $display("FAIL %s bus_signals: we/addr/wdata unstable or busreq outside access (we=%b addr=%h wdata=%h)", nm, bus_we, bus_addr, bus_wdata);
    end
    exp_rdata = exp_rd;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vec_cnt++;
    if ({stall, bus_req, bus_we, mis_err, to_err} !== 5'b0 ||
        bus_addr !== '0 || bus_wdata !== '0 || mem_rdata !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: stall=%b req=%b we=%b addr=%h wdata=%h rdata=%h mis=%b to=%b required all 0",
               stall, bus_req, bus_we, bus_addr, bus_wdata, mem_rdata, mis_err, to_err);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    exp_rdata = '0;
    exp_mis   = 1'b0;
    exp_to    = 1'b0;
    @(negedge clk);
  endtask

  // Short-timeout instance: a good load first so the abort visibly clears rdata.
  task automatic test_timeout_t4();
    int n_req = 0;
    int n_stall = 0;
    int cyc = 0;
    do_access(32'h0000_0200, 32'h0, 1'b1, 1'b0, 1, 32'hA5A5_5A5A, "t4_preload");
    vec_cnt++;
    if (mem_rdata_t4 !== 32'hA5A5_5A5A) begin
      err_cnt++;
      $display("FAIL t4_preload_rdata: got %h required a5a55a5a", mem_rdata_t4);
    end
    mem_addr = 32'h0000_0300; mem_read = 1'b1; mem_write = 1'b0;
    #1;
    while (stall_t4 === 1'b1 && cyc < 32) begin
      n_stall++;
      if (bus_req_t4 === 1'b1) n_req++;
      @(negedge clk); #1;
      cyc++;
    end
    vec_cnt++;
    if (n_req !== c_TO_T4) begin
      err_cnt++;
      $display("FAIL t4_busreq_cycles: got %0d required %0d", n_req, c_TO_T4);
    end
    vec_cnt++;
    if (n_stall !== c_TO_T4 + 1) begin
      err_cnt++;
      $display("FAIL t4_stall_cycles: got %0d required %0d", n_stall, c_TO_T4 + 1);
    end
    vec_cnt++;
    if (to_err_t4 !== 1'b1 || mem_rdata_t4 !== '0 || bus_req_t4 !== 1'b0) begin
      err_cnt++;
      $display("FAIL t4_abort: got to=%b rdata=%h req=%b required to=1 rdata=0 req=0", to_err_t4, mem_rdata_t4, bus_req_t4);
    end
    mem_read = 1'b0;
    @(negedge clk);
    pulse_reset();
  endtask

  task automatic test_directed();
    do_access(32'h0000_0100, 32'h0,         1'b1, 1'b0, 0,   32'hCAFE_F00D, "load_0x100");
    do_access(32'h0000_2004, 32'h1234_5678, 1'b0, 1'b1, 5,   32'hDEAD_BEEF, "store_0x2004");
    do_access(32'h0000_0102, 32'h0,         1'b1, 1'b0, 0,   32'h1111_1111, "misaligned_0x102");
    do_access(32'h0000_0500, 32'h0,         1'b1, 1'b0, 100, 32'h2222_2222, "timeout_main");
    do_access(32'h0000_0504, 32'h0,         1'b1, 1'b0, c_TO_MAIN - 1, 32'h3333_3333, "ack_at_timeout");
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    do_access(32'h0000_0040, 32'h0BAD_F00D, 1'b1, 1'b1, 1, 32'h4444_4444, "rd_wr_both");
    do_access(32'h0000_0040, 32'h0,         1'b1, 1'b0, 0, 32'h5555_5555, "b2b_load_0x40");
    do_access(32'h0000_0044, 32'h0,         1'b1, 1'b0, 2, 32'h6666_6666, "b2b_load_0x44");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int          sel;
      int          gap;
      a   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      sel = $urandom_range(0, 2);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        #1;
        vec_cnt++;
        if (stall !== 1'b0 || bus_req !== 1'b0) begin
          err_cnt++;
          $display("FAIL rand_idle: stall=%b req=%b required 0 0", stall, bus_req);
        end
        @(negedge clk);
      end
      do_access(a, $urandom, (sel != 1), (sel != 0), $urandom_range(0, c_TO_MAIN + 1),
                $urandom, "random");
    end
  endtask

  task automatic test_reset_mid();
    mem_addr = 32'h0000_0800; mem_read = 1'b1; mem_write = 1'b0;
    @(negedge clk);
    mem_read = 1'b0;
    #1;
    vec_cnt++;
    if (bus_req !== 1'b1) begin
      err_cnt++;
      $display("FAIL mid_req_active: got %b required 1", bus_req);
    end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (bus_req !== 1'b0 || stall !== 1'b0) begin
      err_cnt++;
      $display("FAIL mid_async_drop: req=%b stall=%b required 0 0", bus_req, stall);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_ack   = 1'b1;
    bus_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk); #1;
    vec_cnt++;
    if (bus_req !== 1'b0 || stall !== 1'b0 || mem_rdata !== '0 ||
        mis_err !== 1'b0 || to_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL stray_ack: req=%b stall=%b rdata=%h mis=%b to=%b required all 0",
               bus_req, stall, mem_rdata, mis_err, to_err);
    end
    exp_rdata = '0; exp_mis = 1'b0; exp_to = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    exp_rdata = '0;
    exp_mis   = 1'b0;
    exp_to    = 1'b0;
    test_reset();
    test_timeout_t4();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
